uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
- REQ-001: Parameter HDR0, default 8'hA0, header byte sent before a port-0 word.
- REQ-002: Parameter HDR1, default 8'hA1, header byte sent before a port-1 word.
- REQ-003: Parameter BUSY_TO, default 16, cycles to wait for tx_busy to rise before proceeding anyway.
- REQ-004: clk  input  1  single clock; all logic on rising edge.
- REQ-005: rst  input  1  asynchronous, active-low reset (asserted when 0).
- REQ-006: req0  input  1  port 0 has a 32-bit word to send; level, held until ack0.
- REQ-007: data0  input  32  port 0 word; sampled only in the ack0 cycle.
- REQ-008: ack0  output  1  one-cycle pulse; port 0 word latched.
- REQ-009: req1  input  1  port 1 request; same rules as req0.
- REQ-010: data1  input  32  port 1 word.
- REQ-011: ack1  output  1  one-cycle pulse; port 1 word latched.
- REQ-012: tx_busy  input  1  UART transmitter busy.
- REQ-013: tx_data  output  8  byte to UART transmitter.
- REQ-014: new_tx_data  output  1  one-cycle strobe; tx_data valid.
- REQ-015: busy  output  1  high in every state except IDLE.
- REQ-016: grant_id  output  1  port owning the current packet; holds its last value in IDLE.

Function
- REQ-017: States IDLE, LOAD, SEND, WAIT_HI, WAIT_LO; one-hot or encoded, with no other reachable state.
- REQ-018: Packet = 5 bytes, in order: header (HDR0/HDR1), word[7:0], word[15:8], word[23:16], word[31:24].
- REQ-019: IDLE: if req0 or req1, go to LOAD next cycle and set grant_id by the arbitration rule; otherwise stay.
- REQ-020: Arbitration: single request wins; if both are asserted, grant the port not granted last (round-robin); after reset the last grant is port 1, so port 0 wins the first tie.
- REQ-021: LOAD (1 cycle): latch the granted data word, pulse the granted ack, clear byte_cnt to 0, go to SEND.
- REQ-022: SEND (1 cycle): drive tx_data = byte[byte_cnt], new_tx_data = 1, clear timeout counter, go to WAIT_HI.
- REQ-023: WAIT_HI: on tx_busy = 1, go to WAIT_LO.
- REQ-024: WAIT_HI timeout: increment the counter each cycle; when the count reaches BUSY_TO-1 with tx_busy still 0, go to WAIT_LO.
- REQ-025: WAIT_LO: while tx_busy = 1, stay.
- REQ-026: WAIT_LO exit: on tx_busy = 0, go to IDLE if byte_cnt = 4, else increment byte_cnt and go to SEND.
- REQ-027: Minimum spacing between new_tx_data strobes is 3 cycles (SEND, WAIT_HI, WAIT_LO).
- REQ-028: tx_data holds its last value outside SEND; new_tx_data is 0 in every state except SEND.
- REQ-029: Requests arriving during a packet are not acknowledged until IDLE; no word is lost or duplicated.
- REQ-030: Deassertion of req while its packet is in flight does not affect that packet.
- REQ-031: ack0 and ack1 are never high in the same cycle; at most one ack per packet.
- REQ-032: The block adds no latency inside the UART transmitter; back-to-back packets: IDLE to LOAD is 1 cycle after the final WAIT_LO exit.
- REQ-033: Timeout counter width is clog2(BUSY_TO)+1 and it does not wrap within one WAIT_HI visit.

Reset
- REQ-034: rst = 0 forces IDLE asynchronously, including mid-packet; the partially sent packet is abandoned and not resumed.
- REQ-035: Reset values: tx_data = 8'h00, new_tx_data = 0, ack0 = 0, ack1 = 0, busy = 0, grant_id = 1, byte_cnt = 0, timeout counter = 0, latched word = 0.
- REQ-036: Arbitration resumes on the first rising edge with rst = 1.

Verification
- REQ-037: req0 = 1, data0 = 32'h11223344; tx model raises busy 2 cycles after each strobe, holds it 10 cycles -> ack0 pulse once; strobes carry A0, 44, 33, 22, 11; busy drops after the 5th byte completes.
- REQ-038: req0 and req1 asserted together from reset -> port 0 packet first, then port 1 (header A1); with both held continuously, grants alternate 0, 1, 0, 1.
- REQ-039: tx_busy tied 0, BUSY_TO = 16 -> each byte advances after 16 WAIT_HI cycles; 5 strobes, correct byte order, no hang.
- REQ-040: rst pulsed low during byte 2 of a port-1 packet -> outputs return to reset values immediately; a new req0 after release sends a full fresh packet starting with header A0.
- REQ-041: req1 rises while a port-0 packet is mid-flight -> ack1 only after port-0 byte 5 completes, with LOAD 1 cycle after IDLE.
- REQ-042: Assertion checks run throughout: new_tx_data never high while tx_busy = 1 in WAIT_LO; ack0 and ack1 never high together; new_tx_data strobes never closer than 3 cycles apart.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Two-port round-robin arbiter that frames 32-bit words as 5-byte packets
// (header + LSB-first word) and paces them into a byte-wide UART transmitter.
module uart_tx_arb #(
    parameter logic [7:0]  HDR0    = 8'hA0,
    parameter logic [7:0]  HDR1    = 8'hA1,
    parameter int unsigned BUSY_TO = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        ack1,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    output logic        busy,
    output logic        grant_id
);

    localparam int TW = $clog2(BUSY_TO) + 1;
    localparam logic [TW-1:0] TO_MAX = TW'(BUSY_TO - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SEND    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    state_t         state_q;
    logic           grant_q;
    logic           grant_d;
    logic           ack0_q;
    logic           ack1_q;
    logic           new_tx_q;
    logic [7:0]     tx_data_q;
    logic [31:0]    word_q;
    logic [2:0]     byte_cnt_q;
    logic [TW-1:0]  to_cnt_q;
    logic [7:0]     word_byte_d;

    // Round-robin on a tie: the port not granted last wins.
    always_comb begin
        grant_d = grant_q;
        if (req0 && req1) begin
            grant_d = ~grant_q;
        end else if (req1) begin
            grant_d = 1'b1;
        end else if (req0) begin
            grant_d = 1'b0;
        end
    end

    // Payload byte sent after the current one: byte_cnt n selects word byte n.
    always_comb begin
        word_byte_d = 8'h00;
        case (byte_cnt_q)
            3'd0:    word_byte_d = word_q[7:0];
            3'd1:    word_byte_d = word_q[15:8];
            3'd2:    word_byte_d = word_q[23:16];
            3'd3:    word_byte_d = word_q[31:24];
            default: word_byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            new_tx_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            word_q     <= 32'h0;
            byte_cnt_q <= 3'd0;
            to_cnt_q   <= '0;
        end else begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            new_tx_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q <= grant_d;
                        ack0_q  <= ~grant_d;
                        ack1_q  <= grant_d;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    word_q     <= grant_q ? data1 : data0;
                    byte_cnt_q <= 3'd0;
                    tx_data_q  <= grant_q ? HDR1 : HDR0;
                    new_tx_q   <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    to_cnt_q <= '0;
                    state_q  <= WAIT_HI;
                end
                WAIT_HI: begin
                    // Give up on tx_busy ever rising after BUSY_TO cycles.
                    if (tx_busy || (to_cnt_q == TO_MAX)) begin
                        state_q <= WAIT_LO;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (byte_cnt_q == 3'd4) begin
                            state_q <= IDLE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                            tx_data_q  <= word_byte_d;
                            new_tx_q   <= 1'b1;
                            state_q    <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign new_tx_data = new_tx_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: scoreboard of expected bytes/grants,
// a simple UART busy model, and per-strobe protocol checks.
module tb_uart_tx_arb;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [31:0] data0;
    logic        ack0;
    logic        req1;
    logic [31:0] data1;
    logic        ack1;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        busy;
    logic        grant_id;

    uart_tx_arb #(.HDR0(8'hA0), .HDR1(8'hA1), .BUSY_TO(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .tx_busy(tx_busy), .tx_data(tx_data), .new_tx_data(new_tx_data),
        .busy(busy), .grant_id(grant_id)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_strobe = -1;
    int nack0 = 0;
    int nack1 = 0;
    bit model_en = 1'b1;
    int m;
    logic [7:0] exp_q[$];
    bit         ack_q[$];
    int         st_t[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic push_pkt(input bit p, input logic [31:0] w);
        exp_q.push_back(p ? 8'hA1 : 8'hA0);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
        ack_q.push_back(p);
    endtask

    task automatic wait_ack(input string tag, output bit port);
        port = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                port = ack1;
                return;
            end
        end
        timeout_fail(tag);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) return;
        end
        timeout_fail(tag);
    endtask

    task automatic wait_strobes(input string tag, input int n);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (st_t.size() >= n) return;
        end
        timeout_fail(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_data"}, tx_data, 8'h00);
        chk({tag, "_new_tx"},  new_tx_data, 1'b0);
        chk({tag, "_ack0"},    ack0, 1'b0);
        chk({tag, "_ack1"},    ack1, 1'b0);
        chk({tag, "_busy"},    busy, 1'b0);
        chk({tag, "_grant"},   grant_id, 1'b1);
    endtask

    // UART model: busy rises 2 cycles after a strobe and stays up 10 cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst || !model_en) begin
            m       <= 0;
            tx_busy <= 1'b0;
        end else begin
            tx_busy <= (m >= 1 && m <= 10);
            if (new_tx_data)           m <= 1;
            else if (m != 0 && m < 12) m <= m + 1;
            else                       m <= 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (new_tx_data) begin
                chk("tx_vs_busy", tx_busy, 1'b0);
                if (exp_q.size() == 0) chk("tx_unexpected", 32'(exp_q.size()), 1);
                else chk("tx_byte", tx_data, exp_q.pop_front());
                if (last_strobe >= 0) chk("strobe_spacing", 32'(cyc - last_strobe >= 3), 1);
                last_strobe = cyc;
                st_t.push_back(cyc);
            end
            if (ack0 || ack1) begin
                chk("ack_exclusive", ack0 & ack1, 1'b0);
                if (ack0) nack0++;
                if (ack1) nack1++;
                if (ack_q.size() == 0) chk("ack_unexpected", 32'(ack_q.size()), 1);
                else begin
                    bit p;
                    p = ack_q.pop_front();
                    chk("ack_port", ack1, p);
                    chk("grant_id", grant_id, p);
                end
            end
        end
    end

    initial begin
        bit p;
        int n0, n1, a0;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_init");
        rst = 1'b1;

        // Single port-0 packet with the busy model.
        st_t.delete();
        a0 = nack0;
        push_pkt(1'b0, 32'h11223344);
        req0 = 1'b1; data0 = 32'h11223344;
        wait_ack("t1_ack", p);
        @(posedge clk); #1;
        req0 = 1'b0; data0 = 32'hFFFFFFFF;
        wait_idle("t1_idle");
        repeat (3) @(negedge clk);
        chk("t1_ack0_once", 32'(nack0 - a0), 1);
        chk("t1_strobes", 32'(st_t.size()), 5);
        for (int i = 1; i < st_t.size(); i++) chk("t1_gap", 32'(st_t[i] - st_t[i-1]), 13);
        chk("t1_busy_low", busy, 1'b0);

        // Tie from reset: port 0 first, then alternate while both held.
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        push_pkt(1'b0, 32'hA5A5_0001);
        push_pkt(1'b1, 32'h5A5A_0002);
        push_pkt(1'b0, 32'hC3C3_0003);
        push_pkt(1'b1, 32'h3C3C_0004);
        data0 = 32'hA5A5_0001; data1 = 32'h5A5A_0002;
        req0 = 1'b1; req1 = 1'b1;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack("t2_ack", p);
            @(posedge clk); #1;
            if (!p) begin
                n0++;
                if (n0 == 1) data0 = 32'hC3C3_0003; else req0 = 1'b0;
            end else begin
                n1++;
                if (n1 == 1) data1 = 32'h3C3C_0004; else req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_idle("t2_idle");
        chk("t2_acks_left", 32'(ack_q.size()), 0);

        // tx_busy stuck low: every byte advances on the WAIT_HI timeout.
        model_en = 1'b0;
        @(negedge clk);
        st_t.delete();
        push_pkt(1'b1, 32'hDEADBEEF);
        req1 = 1'b1; data1 = 32'hDEADBEEF;
        wait_ack("t3_ack", p);
        @(posedge clk); #1 req1 = 1'b0;
        wait_idle("t3_idle");
        chk("t3_strobes", 32'(st_t.size()), 5);
        for (int i = 1; i < st_t.size(); i++) chk("t3_gap", 32'(st_t[i] - st_t[i-1]), 18);
        model_en = 1'b1;

        // Reset during byte 2 of a port-1 packet, then a fresh port-0 packet.
        st_t.delete();
        push_pkt(1'b1, 32'hCAFEF00D);
        req1 = 1'b1; data1 = 32'hCAFEF00D;
        wait_ack("t4_ack", p);
        @(posedge clk); #1 req1 = 1'b0;
        wait_strobes("t4_strobes", 3);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        ack_q.delete();
        #1 chk_reset_vals("t4_async");
        @(negedge clk); rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_no_resume_busy", busy, 1'b0);
        chk("t4_no_resume_tx", 32'(st_t.size()), 3);
        push_pkt(1'b0, 32'h55667788);
        req0 = 1'b1; data0 = 32'h55667788;
        wait_ack("t4b_ack", p);
        @(posedge clk); #1 req0 = 1'b0;
        wait_idle("t4b_idle");

        // req1 arrives mid port-0 packet: ack1 only after its last byte.
        st_t.delete();
        push_pkt(1'b0, 32'h0BADBEEF);
        req0 = 1'b1; data0 = 32'h0BADBEEF;
        wait_ack("t5_ack0", p);
        @(posedge clk); #1 req0 = 1'b0;
        wait_strobes("t5_strobes", 2);
        push_pkt(1'b1, 32'h87654321);
        req1 = 1'b1; data1 = 32'h87654321;
        begin
            bit seen_idle;
            seen_idle = 1'b0;
            for (int i = 0; i < 400 && !seen_idle; i++) begin
                @(negedge clk);
                if (!busy) seen_idle = 1'b1;
            end
            if (!seen_idle) timeout_fail("t5_idle");
        end
        chk("t5_no_early_ack1", ack1, 1'b0);
        chk("t5_port0_done", 32'(st_t.size()), 5);
        chk("t5_port1_pending", 32'(exp_q.size()), 5);
        @(negedge clk);
        chk("t5_ack1_next", ack1, 1'b1);
        @(posedge clk); #1 req1 = 1'b0;
        wait_idle("t5_idle_end");
        chk("end_exp_empty", 32'(exp_q.size()), 0);
        chk("end_ack_empty", 32'(ack_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
